// File: rtl/packet_assembler_pkg.sv
// packet_assembler_pkg
//   Shared definitions for the UART command packet framer and the
//   downstream packet decoder: framing bytes, FSM state encoding and
//   the layout of the payload byte.
package packet_assembler_pkg;

    localparam logic [7:0] PKT_HEADER       = 8'hFF;
    localparam logic [7:0] PKT_FOOTER       = 8'hFF;
    localparam logic [7:0] PKT_STOP_PAYLOAD = 8'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PAY = 2'd1,
        WAIT_FTR = 2'd2
    } pa_state_e;

    // Payload byte layout: data[7:4], y[3:2], x[1:0].
    typedef struct packed {
        logic [3:0] data;
        logic [1:0] y;
        logic [1:0] x;
    } payload_t;

    function automatic logic [23:0] make_frame(input logic [7:0] payload);
        return {PKT_HEADER, payload, PKT_FOOTER};
    endfunction

endpackage

// File: rtl/packet_assembler_cycle_timeout.sv
// cycle_timeout
//   Counts enabled cycles and flags expiry on the cycle the count has
//   reached LIMIT-1. A clear in the same cycle suppresses the expiry.
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   clear    in   restart the count from zero
//   enable   in   count while high; count is held at zero while low
//   expired  out  combinational, high for the cycle the limit is reached
module cycle_timeout #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = enable && !clear && (count_q == LAST);

    // Restart after expiry so the next enabled period starts from zero.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || !enable || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// packet_assembler
//   Frames the UART receiver byte stream into {HEADER, payload, FOOTER}
//   packets and presents the last good packet to the decoder. Resyncs on
//   garbage, times out stalled frames and forces a stop frame when no good
//   packet has arrived for LINK_TIMEOUT_CYCLES.
// Ports
//   clk             in   system clock
//   reset           in   synchronous, active-high
//   rx_byte         in   received byte, valid when rx_valid=1
//   rx_valid        in   one-cycle strobe per byte
//   received_bytes  out  last good frame, or stop frame after link loss
//   packet_valid    out  one-cycle pulse when a good frame is loaded
//   frame_error     out  one-cycle pulse on footer mismatch
//   timeout_error   out  one-cycle pulse on inter-byte timeout
//   link_ok         out  high while good packets keep arriving
//   error_count     out  saturating count of frame/timeout errors
module packet_assembler
    import packet_assembler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES      = 50_000,
    parameter int unsigned LINK_TIMEOUT_CYCLES = 25_000_000,
    parameter int unsigned ERR_CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    output logic [23:0]          received_bytes,
    output logic                 packet_valid,
    output logic                 frame_error,
    output logic                 timeout_error,
    output logic                 link_ok,
    output logic [ERR_CNT_W-1:0] error_count
);

    pa_state_e            state_q, state_d;
    payload_t             payload_q, payload_d;
    logic [23:0]          received_q, received_d;
    logic                 packet_valid_q, packet_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 timeout_error_q, timeout_error_d;
    logic                 link_ok_q, link_ok_d;
    logic [ERR_CNT_W-1:0] error_count_q, error_count_d;

    logic good_packet;
    logic byte_timeout;
    logic link_expired;

    // Kept outside the FSM process so the link timer clear does not form a
    // combinational path back through that process.
    assign good_packet = (state_q == WAIT_FTR) && rx_valid && (rx_byte == PKT_FOOTER);

    cycle_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_byte_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_valid),
        .enable  (state_q != IDLE),
        .expired (byte_timeout)
    );

    cycle_timeout #(.LIMIT(LINK_TIMEOUT_CYCLES)) u_link_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (good_packet),
        .enable  (link_ok_q),
        .expired (link_expired)
    );

    // A byte arriving on the expiry cycle takes priority: the timer sees the
    // clear and never reports expiry, so only the byte path acts.
    always_comb begin
        state_d         = state_q;
        payload_d       = payload_q;
        received_d      = received_q;
        packet_valid_d  = 1'b0;
        frame_error_d   = 1'b0;
        timeout_error_d = 1'b0;
        link_ok_d       = link_ok_q;
        error_count_d   = error_count_q;

        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_byte == PKT_HEADER)) begin
                    state_d = WAIT_PAY;
                end
            end
            WAIT_PAY: begin
                if (rx_valid) begin
                    payload_d = payload_t'(rx_byte);
                    state_d   = WAIT_FTR;
                end else if (byte_timeout) begin
                    timeout_error_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            WAIT_FTR: begin
                if (rx_valid) begin
                    if (good_packet) begin
                        received_d     = make_frame(payload_q);
                        packet_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (byte_timeout) begin
                    timeout_error_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Expiry is already masked by the timer clear when a good packet lands.
        if (good_packet) begin
            link_ok_d = 1'b1;
        end else if (link_expired) begin
            link_ok_d  = 1'b0;
            received_d = make_frame(PKT_STOP_PAYLOAD);
        end

        if ((frame_error_d || timeout_error_d) && (error_count_q != '1)) begin
            error_count_d = error_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            payload_q       <= '0;
            received_q      <= '0;
            packet_valid_q  <= 1'b0;
            frame_error_q   <= 1'b0;
            timeout_error_q <= 1'b0;
            link_ok_q       <= 1'b0;
            error_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            payload_q       <= payload_d;
            received_q      <= received_d;
            packet_valid_q  <= packet_valid_d;
            frame_error_q   <= frame_error_d;
            timeout_error_q <= timeout_error_d;
            link_ok_q       <= link_ok_d;
            error_count_q   <= error_count_d;
        end
    end

    assign received_bytes = received_q;
    assign packet_valid   = packet_valid_q;
    assign frame_error    = frame_error_q;
    assign timeout_error  = timeout_error_q;
    assign link_ok        = link_ok_q;
    assign error_count    = error_count_q;

endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler
//   Directed bench for packet_assembler with short timers
//   (TIMEOUT_CYCLES=16, LINK_TIMEOUT_CYCLES=64). Inputs change 1 ns after
//   the rising edge and outputs are sampled at that same point.
module tb_packet_assembler;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [23:0] received_bytes;
    logic        packet_valid;
    logic        frame_error;
    logic        timeout_error;
    logic        link_ok;
    logic [7:0]  error_count;

    int checks = 0;
    int errors = 0;

    packet_assembler #(
        .TIMEOUT_CYCLES      (16),
        .LINK_TIMEOUT_CYCLES (64),
        .ERR_CNT_W           (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .received_bytes (received_bytes),
        .packet_valid   (packet_valid),
        .frame_error    (frame_error),
        .timeout_error  (timeout_error),
        .link_ok        (link_ok),
        .error_count    (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one byte for exactly one rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_rx_bytes", 32'(received_bytes), 32'h000000);
        checkOutput("rst_pv",       32'(packet_valid),   32'h0);
        checkOutput("rst_ferr",     32'(frame_error),    32'h0);
        checkOutput("rst_terr",     32'(timeout_error),  32'h0);
        checkOutput("rst_link",     32'(link_ok),        32'h0);
        checkOutput("rst_errcnt",   32'(error_count),    32'h0);

        // 1: basic good packet
        applyStimulus(8'hFF);
        applyStimulus(8'h25);
        checkOutput("t1_pv_early", 32'(packet_valid), 32'h0);
        applyStimulus(8'hFF);
        checkOutput("t1_pv",       32'(packet_valid),   32'h1);
        checkOutput("t1_rx_bytes", 32'(received_bytes), 32'hFF25FF);
        checkOutput("t1_link",     32'(link_ok),        32'h1);
        idleCycles(1);
        checkOutput("t1_pv_drop",  32'(packet_valid),   32'h0);

        // 2: garbage resync, payload FF accepted
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        checkOutput("t2_no_ferr",  32'(frame_error),    32'h0);
        applyStimulus(8'hFF);
        applyStimulus(8'hFF);
        applyStimulus(8'hFF);
        checkOutput("t2_pv",       32'(packet_valid),   32'h1);
        checkOutput("t2_rx_bytes", 32'(received_bytes), 32'hFFFFFF);
        checkOutput("t2_errcnt",   32'(error_count),    32'h0);

        // 3: footer mismatch
        applyStimulus(8'hFF);
        applyStimulus(8'h25);
        applyStimulus(8'h00);
        checkOutput("t3_ferr",     32'(frame_error),    32'h1);
        checkOutput("t3_pv",       32'(packet_valid),   32'h0);
        checkOutput("t3_errcnt",   32'(error_count),    32'h1);
        checkOutput("t3_rx_bytes", 32'(received_bytes), 32'hFFFFFF);
        idleCycles(1);
        checkOutput("t3_ferr_drop", 32'(frame_error),   32'h0);

        // 4a: inter-byte timeout after a lone header
        applyStimulus(8'hFF);
        idleCycles(15);
        checkOutput("t4_terr_early", 32'(timeout_error), 32'h0);
        idleCycles(1);
        checkOutput("t4_terr",       32'(timeout_error), 32'h1);
        checkOutput("t4_errcnt",     32'(error_count),   32'h2);
        idleCycles(1);
        checkOutput("t4_terr_drop",  32'(timeout_error), 32'h0);
        // FSM must be back in IDLE: FF is a header again, not a footer
        applyStimulus(8'hFF);
        applyStimulus(8'h07);
        checkOutput("t4_idle_ferr",  32'(frame_error),   32'h0);
        applyStimulus(8'hFF);
        checkOutput("t4_idle_frame", 32'(received_bytes), 32'hFF07FF);

        // 4b: byte on the expiry cycle wins
        applyStimulus(8'hFF);
        idleCycles(15);
        applyStimulus(8'h3C);
        checkOutput("t4b_no_terr",   32'(timeout_error), 32'h0);
        checkOutput("t4b_errcnt",    32'(error_count),   32'h2);
        applyStimulus(8'hFF);
        checkOutput("t4b_pv",        32'(packet_valid),   32'h1);
        checkOutput("t4b_rx_bytes",  32'(received_bytes), 32'hFF3CFF);

        // 5: link loss 64 cycles after the last good packet
        idleCycles(63);
        checkOutput("t5_link_early", 32'(link_ok),        32'h1);
        checkOutput("t5_rx_early",   32'(received_bytes), 32'hFF3CFF);
        idleCycles(1);
        checkOutput("t5_link_lost",  32'(link_ok),        32'h0);
        checkOutput("t5_stop_frame", 32'(received_bytes), 32'hFF00FF);
        checkOutput("t5_no_pv",      32'(packet_valid),   32'h0);

        // 5b: good packet landing on the link expiry cycle wins
        applyStimulus(8'hFF);
        applyStimulus(8'h22);
        applyStimulus(8'hFF);
        checkOutput("t5b_link_up",   32'(link_ok),        32'h1);
        idleCycles(61);
        applyStimulus(8'hFF);
        applyStimulus(8'h11);
        applyStimulus(8'hFF);
        checkOutput("t5b_link",      32'(link_ok),        32'h1);
        checkOutput("t5b_rx_bytes",  32'(received_bytes), 32'hFF11FF);
        checkOutput("t5b_pv",        32'(packet_valid),   32'h1);
        idleCycles(1);
        checkOutput("t5b_link_hold", 32'(link_ok),        32'h1);

        // 6: reset mid-frame discards the partial frame
        applyStimulus(8'hFF);
        applyStimulus(8'h07);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("t6_rst_rx",     32'(received_bytes), 32'h000000);
        checkOutput("t6_rst_link",   32'(link_ok),        32'h0);
        checkOutput("t6_rst_errcnt", 32'(error_count),    32'h0);
        applyStimulus(8'hFF);
        checkOutput("t6_pv_early",   32'(packet_valid),   32'h0);
        applyStimulus(8'h07);
        applyStimulus(8'hFF);
        checkOutput("t6_pv",         32'(packet_valid),   32'h1);
        checkOutput("t6_rx_bytes",   32'(received_bytes), 32'hFF07FF);
        checkOutput("t6_errcnt",     32'(error_count),    32'h0);

        // 6b: error counter saturation
        for (int i = 0; i < 255; i++) begin
            applyStimulus(8'hFF);
            applyStimulus(8'h25);
            applyStimulus(8'h00);
        end
        checkOutput("t6_errcnt_255", 32'(error_count), 32'hFF);
        for (int i = 0; i < 45; i++) begin
            applyStimulus(8'hFF);
            applyStimulus(8'h25);
            applyStimulus(8'h00);
        end
        checkOutput("t6_errcnt_sat", 32'(error_count), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
